// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the 2-read/1-write register file.
//   - clr_state_e : clear-sweep FSM state encoding
//   - REGFILE_DATA_W_DEF / REGFILE_DEPTH_DEF : default geometry
package regfile_pkg;

    localparam int REGFILE_DATA_W_DEF = 32;
    localparam int REGFILE_DEPTH_DEF  = 8;

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: whole-file clear sequencer.
// A clr_start pulse in IDLE starts a sweep that zeroes one entry per cycle,
// from address 0 up to DEPTH-1, then returns to IDLE.
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   clr_start in   request a sweep (ignored while sweeping)
//   clr_busy  out  high for exactly DEPTH cycles while sweeping
//   clr_en    out  entry clr_addr is zeroed at the next rising edge
//   clr_addr  out  entry currently being zeroed
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH  = REGFILE_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    // State and sweep-pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLR_IDLE;
            r_ptr   <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic: the pointer walks 0..DEPTH-1 once per sweep.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            CLR_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = CLR_SWEEP;
                    w_ptr_nxt   = {ADDR_W{1'b0}};
                end else begin
                    w_state_nxt = CLR_IDLE;
                end
            end
            CLR_SWEEP: begin
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = CLR_IDLE;
                    w_ptr_nxt   = {ADDR_W{1'b0}};
                end else begin
                    w_ptr_nxt   = r_ptr + ADDR_W'(1'b1);
                end
            end
            default: begin
                w_state_nxt = CLR_IDLE;
                w_ptr_nxt   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Outputs come straight from the state registers.
    assign clr_busy = (r_state == CLR_SWEEP);
    assign clr_en   = (r_state == CLR_SWEEP);
    assign clr_addr = r_ptr;

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x DATA_W register file, one write port, two
// independent registered read ports with write-first bypass, per-port
// read-valid strobes and a sequenced whole-file clear.
// Optional feature macro: REGFILE_ZERO_REG_EN -- entry 0 reads as zero,
// ignores writes and has no storage.
// Ports:
//   clk, reset_n                 clock / asynchronous active-low reset
//   we, wr_addr, wr_data         write port
//   re0/re1, rd_addr0/rd_addr1   read requests and addresses
//   rd_data0/rd_data1            registered read data (held when not read)
//   rd_valid0/rd_valid1          one-cycle strobe: rd_dataN updated
//   clr_start, clr_busy          start / status of the clear sweep
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W_DEF,
    parameter int DEPTH  = REGFILE_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_valid0,
    output logic              rd_valid1,
    input  logic              clr_start,
    output logic              clr_busy
);

`ifdef REGFILE_ZERO_REG_EN
    localparam int FIRST_ENTRY = 1;
`else
    localparam int FIRST_ENTRY = 0;
`endif

    logic [DATA_W-1:0] r_mem [FIRST_ENTRY:DEPTH-1];

    logic              w_clr_busy;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_hit;

    logic              w_re      [2];
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_nxt  [2];
    logic [DATA_W-1:0] r_rd_data [2];
    logic              r_rd_valid[2];

    // True when the address names a physically stored entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) >= FIRST_ENTRY) && (int'(a) < DEPTH);
    endfunction

    regfile_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_start (clr_start),
        .clr_busy  (w_clr_busy),
        .clr_en    (w_clr_en),
        .clr_addr  (w_clr_addr)
    );

    // Writes are dropped while sweeping and when they target no storage.
    assign w_wr_hit = we && !w_clr_busy && addr_ok(wr_addr);

    assign w_re[0]      = re0;
    assign w_re[1]      = re1;
    assign w_rd_addr[0] = rd_addr0;
    assign w_rd_addr[1] = rd_addr1;

    // Storage: sweep zeroing and accepted writes (never both in one cycle).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = FIRST_ENTRY; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_clr_en && addr_ok(w_clr_addr)) begin
            r_mem[w_clr_addr] <= {DATA_W{1'b0}};
        end else if (w_wr_hit) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read value per port = the entry's value after this edge (write-first,
    // and an entry being swept reads as zero).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_nxt[p] = {DATA_W{1'b0}};
            if (!addr_ok(w_rd_addr[p])) begin
                w_rd_nxt[p] = {DATA_W{1'b0}};
            end else if (w_clr_en && (w_clr_addr == w_rd_addr[p])) begin
                w_rd_nxt[p] = {DATA_W{1'b0}};
            end else if (w_wr_hit && (wr_addr == w_rd_addr[p])) begin
                w_rd_nxt[p] = wr_data;
            end else begin
                w_rd_nxt[p] = r_mem[w_rd_addr[p]];
            end
        end
    end

    // Read data / valid registers; data holds when the port is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                r_rd_data[p]  <= {DATA_W{1'b0}};
                r_rd_valid[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_re[p]) begin
                    r_rd_data[p]  <= w_rd_nxt[p];
                    r_rd_valid[p] <= 1'b1;
                end else begin
                    r_rd_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign rd_data0  = r_rd_data[0];
    assign rd_data1  = r_rd_data[1];
    assign rd_valid0 = r_rd_valid[0];
    assign rd_valid1 = r_rd_valid[1];
    assign clr_busy  = w_clr_busy;

endmodule
